control_sequencer: RTL and testbench

//   Sequenced, parametrised control-word generator for the processor datapath.
//   On start, latches two indices A and B and steps an index from min(A,B) to max(A,B), up or down.

---
 rtl/ctrl_seq_if.sv | 38 +++
 rtl/control_sequencer.sv | 124 ++++++++++++
 tb/tb_control_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_if.sv
// Handshake bundle between the main controller, the control sequencer and the datapath enables.
// Carries the optional thermo select only when CTRL_SEQ_THERMO_EN is defined.
interface ctrl_seq_if #(
  parameter int IDX_W = 3,
  parameter int OUT_W = 2**IDX_W
) ();
  logic             start;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_b;
  logic             dir;
  logic             abort;
  logic             ready;
`ifdef CTRL_SEQ_THERMO_EN
  logic             thermo;
`endif
  logic             ctrl_valid;
  logic [OUT_W-1:0] ctrl;
  logic [IDX_W-1:0] ctrl_idx;
  logic             ctrl_last;
  logic             busy;
  logic             done;

  modport master (
`ifdef CTRL_SEQ_THERMO_EN
    output thermo,
`endif
    output start, idx_a, idx_b, dir, abort, ready,
    input  ctrl_valid, ctrl, ctrl_idx, ctrl_last, busy, done
  );

  modport slave (
`ifdef CTRL_SEQ_THERMO_EN
    input  thermo,
`endif
    input  start, idx_a, idx_b, dir, abort, ready,
    output ctrl_valid, ctrl, ctrl_idx, ctrl_last, busy, done
  );
endinterface

// File: rtl/control_sequencer.sv
// Steps an index between two latched bounds and emits one decoded control word per accepted step.
// Optional thermometer decode is enabled by defining CTRL_SEQ_THERMO_EN.
module control_sequencer #(
  parameter int IDX_W = 3,
  parameter int OUT_W = 2**IDX_W
) (
  input  logic    clk,
  input  logic    rst_n,
  ctrl_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] end_reg;
  logic             dir_reg;
  logic             valid_reg;
  logic [OUT_W-1:0] ctrl_reg;
  logic             last_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [IDX_W-1:0] lo;
  logic [IDX_W-1:0] hi;
  logic [IDX_W-1:0] load_idx;
  logic             load_thermo;
  logic [OUT_W-1:0] word;

  // In IDLE the next index is the starting bound; in RUN it is one step on from the current index.
  always_comb begin
    lo = (bus.idx_a < bus.idx_b) ? bus.idx_a : bus.idx_b;
    hi = (bus.idx_a < bus.idx_b) ? bus.idx_b : bus.idx_a;
    if (state_reg == IDLE)
      load_idx = bus.dir ? hi : lo;
    else
      load_idx = dir_reg ? (idx_reg - IDX_W'(1)) : (idx_reg + IDX_W'(1));
  end

`ifdef CTRL_SEQ_THERMO_EN
  logic thermo_reg;
  assign load_thermo = (state_reg == IDLE) ? bus.thermo : thermo_reg;
`else
  assign load_thermo = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_word
      assign word[gi] = load_thermo ? (IDX_W'(gi) <= load_idx) : (IDX_W'(gi) == load_idx);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      end_reg   <= '0;
      dir_reg   <= 1'b0;
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef CTRL_SEQ_THERMO_EN
      thermo_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg <= RUN;
            idx_reg   <= load_idx;
            end_reg   <= bus.dir ? lo : hi;
            dir_reg   <= bus.dir;
            ctrl_reg  <= word;
            last_reg  <= (lo == hi);
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
`ifdef CTRL_SEQ_THERMO_EN
            thermo_reg <= bus.thermo;
`endif
          end
        end
        RUN: begin
          // abort wins over a same-cycle handshake, so that word never counts as delivered
          if (bus.abort) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            ctrl_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end else if (bus.ready) begin
            if (last_reg) begin
              state_reg <= DONE;
              idx_reg   <= '0;
              ctrl_reg  <= '0;
              last_reg  <= 1'b0;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              idx_reg  <= load_idx;
              ctrl_reg <= word;
              last_reg <= (load_idx == end_reg);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_valid = valid_reg;
  assign bus.ctrl       = ctrl_reg;
  assign bus.ctrl_idx   = idx_reg;
  assign bus.ctrl_last  = last_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected words are queued at start and popped on each accepted word.
module tb_control_sequencer;
  localparam int IDX_W = 3;

  typedef struct {
    int ctrl;
    int idx;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_seq_if #(.IDX_W(IDX_W)) bus ();

  control_sequencer #(.IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_word(input int idx, input bit th);
    return th ? ((1 << (idx + 1)) - 1) : (1 << idx);
  endfunction

  task automatic push_seq(input int a, input int b, input bit d, input bit th);
    int lo, hi, idx;
    exp_t e;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    for (int s = 0; s <= hi - lo; s++) begin
      idx    = d ? hi - s : lo + s;
      e.ctrl = exp_word(idx, th);
      e.idx  = idx;
      e.last = (s == hi - lo);
      sb.push_back(e);
    end
  endtask

  // Monitor: one line per accepted word
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.ctrl_valid && bus.ready && !bus.abort) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_word", 32'(bus.ctrl), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("word ctrl=0x%02h idx=%0d last=%0d", bus.ctrl, bus.ctrl_idx, bus.ctrl_last);
          check_eq("ctrl", 32'(bus.ctrl), 32'(e.ctrl));
          check_eq("ctrl_idx", 32'(bus.ctrl_idx), 32'(e.idx));
          check_eq("ctrl_last", 32'(bus.ctrl_last), 32'(e.last));
        end
      end
    end
  end

  task automatic drive_inputs(input int a, input int b, input bit d, input bit th);
    bus.idx_a = IDX_W'(a);
    bus.idx_b = IDX_W'(b);
    bus.dir   = d;
`ifdef CTRL_SEQ_THERMO_EN
    bus.thermo = th;
`else
    if (th) $display("note: thermo requested without CTRL_SEQ_THERMO_EN");
`endif
  endtask

  // Runs one sequence; stall_word/abort_word < 0 disable backpressure/abort injection.
  task automatic run_seq(input string tag, input int a, input int b, input bit d, input bit th,
                         input int stall_word, input int abort_word, input int exp_cycles);
    int k, stalls, abort_ph, done0;
    bit finished;
    push_seq(a, b, d, th);
    drive_inputs(a, b, d, th);
    bus.start = 1'b1;
    bus.ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // scramble inputs to show bounds and dir were latched
    drive_inputs($urandom_range(0, 7), $urandom_range(0, 7), ~d, ~th);
    check_eq({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    done0 = done_cnt;
    stalls = 0;
    abort_ph = 0;
    finished = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done || abort_ph == 2) begin
        finished = 1'b1;
        break;
      end
      if (abort_ph == 1) abort_ph = 2;
      if (!bus.ready) begin
        check_eq({tag, "_hold_ctrl"}, 32'(bus.ctrl), 32'(stall_word));
        check_eq({tag, "_hold_valid"}, 32'(bus.ctrl_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      bus.start = (k == 1);
      if (stall_word >= 0 && 32'(bus.ctrl) == 32'(stall_word) && stalls < 3) begin
        bus.ready = 1'b0;
        stalls++;
      end else begin
        bus.ready = 1'b1;
      end
      if (abort_word >= 0 && abort_ph == 0 && 32'(bus.ctrl) == 32'(abort_word)) begin
        bus.abort = 1'b1;
        abort_ph  = 1;
      end
    end
    bus.start = 1'b0;
    #1;
    if (!finished) begin
      check_eq({tag, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end else if (abort_ph == 2) begin
      check_eq({tag, "_abort_valid"}, 32'(bus.ctrl_valid), 32'd0);
      check_eq({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, "_abort_no_done"}, 32'(done_cnt - done0), 32'd0);
      check_eq({tag, "_abort_left"}, 32'(sb.size()), 32'(exp_cycles));
      sb.delete();
      $display("seq %s aborted", tag);
    end else begin
      check_eq({tag, "_cycles"}, 32'(k), 32'(exp_cycles));
      check_eq({tag, "_done_valid"}, 32'(bus.ctrl_valid), 32'd0);
      check_eq({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
      check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
      #1;
      check_eq({tag, "_done_once"}, 32'(done_cnt - done0), 32'd1);
      check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      $display("seq %s complete in %0d cycles", tag, k);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.ctrl_valid), 32'd0);
    check_eq({tag, "_ctrl"}, 32'(bus.ctrl), 32'd0);
    check_eq({tag, "_idx"}, 32'(bus.ctrl_idx), 32'd0);
    check_eq({tag, "_last"}, 32'(bus.ctrl_last), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ready = 1'b1;
    drive_inputs(0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq("t1_fwd", 5, 2, 1'b0, 1'b0, -1, -1, 5);
    run_seq("t2_equal", 3, 3, 1'b1, 1'b0, -1, -1, 2);
    run_seq("t3_stall", 0, 7, 1'b1, 1'b0, 'h40, -1, 12);
    // abort at 0x08 leaves idx 3..6 undelivered
    run_seq("t4_abort", 1, 6, 1'b0, 1'b0, -1, 'h08, 4);
    run_seq("t4_restart", 6, 1, 1'b1, 1'b0, -1, -1, 7);

    // Asynchronous reset mid-sequence
    push_seq(0, 7, 1'b0, 1'b0);
    drive_inputs(0, 7, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
      check_eq("post_rst_valid", 32'(bus.ctrl_valid), 32'd0);
    end
    run_seq("t5_after_rst", 2, 4, 1'b0, 1'b0, -1, -1, 4);

`ifdef CTRL_SEQ_THERMO_EN
    run_seq("t6_thermo", 0, 2, 1'b0, 1'b1, -1, -1, 4);
    run_seq("t6_onehot", 0, 2, 1'b0, 1'b0, -1, -1, 4);
    run_seq("t6_thermo_dn", 7, 4, 1'b1, 1'b1, -1, -1, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
